// File: rtl/ex_unit_pipe_if.sv
// rtl/ex_unit_pipe_if.sv - decode, writeback, branch and data-memory signals of the execute stage
interface ex_unit_pipe_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_class;
   logic [2:0]        in_op;
   logic              in_use_reg;
   logic              in_set_flags;
   logic [3:0]        in_cond;
   logic [REG_AW-1:0] in_dest;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [IMM_W-1:0]  imm;
   logic              out_valid;
   logic              wb_en;
   logic [REG_AW-1:0] wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic              br_taken;
   logic [DATA_W-1:0] br_offset;
   logic [3:0]        flags;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output in_valid, in_class, in_op, in_use_reg, in_set_flags, in_cond, in_dest,
             op_a, op_b, imm, mem_rdata, mem_ack,
      input  in_ready, out_valid, wb_en, wb_dest, wb_data, br_taken, br_offset, flags,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_class, in_op, in_use_reg, in_set_flags, in_cond, in_dest,
             op_a, op_b, imm, mem_rdata, mem_ack,
      output in_ready, out_valid, wb_en, wb_dest, wb_data, br_taken, br_offset, flags,
             mem_rd, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/ex_unit_pipe.sv
// rtl/ex_unit_pipe.sv - registered execute stage: ALU, move/shift, load/store, branch, NZCV
// Define EX_MUL_EN to turn ALU op 7 into an iterative shift-add multiply.
module ex_unit_pipe #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int REG_AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   ex_unit_pipe_if.slave bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MEM_REQ = 2'd1;
   localparam logic [1:0] S_RESP    = 2'd2;
`ifdef EX_MUL_EN
   localparam logic [1:0] S_MUL     = 2'd3;
   localparam int         CNT_W     = $clog2(DATA_W);
`endif
   localparam bit         MOVT_OK   = (2 * IMM_W <= DATA_W);
   localparam int         CMP_W     = IMM_W + 32;
   localparam int         M         = DATA_W - 1;

   logic [1:0]        r_state;
   logic              r_out_valid, r_wb_en, r_br_taken, r_mem_rd, r_mem_wr, r_is_load;
   logic [REG_AW-1:0] r_wb_dest;
   logic [DATA_W-1:0] r_wb_data, r_br_offset, r_mem_addr, r_mem_wdata;
   logic [3:0]        r_flags;

   logic              w_ready, w_accept, w_wen, w_setf, w_mem, w_mul, w_c, w_v, w_sh_big;
   logic [DATA_W-1:0] w_imm_sx, w_imm_zx, w_opb, w_mask_lo, w_res;
   logic [DATA_W:0]   w_sum, w_dif;
   logic [3:0]        w_nzcv;

`ifdef EX_MUL_EN
   logic [DATA_W-1:0] r_mul_a, r_mul_b, r_mul_acc, w_mul_next;
   logic [CNT_W-1:0]  r_mul_cnt;
   logic              r_mul_setf;
   assign w_mul_next = r_mul_acc + (r_mul_b[0] ? r_mul_a : {DATA_W{1'b0}});
`endif

   // RESP is the completion cycle; it already accepts the next op like IDLE does
   assign w_ready   = (r_state == S_IDLE) || (r_state == S_RESP);
   assign w_accept  = bus.in_valid && w_ready;
   assign w_imm_sx  = DATA_W'($signed(bus.imm));
   assign w_imm_zx  = DATA_W'(bus.imm);
   assign w_opb     = bus.in_use_reg ? bus.op_b : w_imm_sx;
   assign w_sum     = {1'b0, bus.op_a} + {1'b0, w_opb};
   assign w_dif     = {1'b0, bus.op_a} - {1'b0, w_opb};
   assign w_mask_lo = DATA_W'({IMM_W{1'b1}});
   assign w_sh_big  = (CMP_W'(bus.imm) >= CMP_W'(DATA_W));

   function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
      logic n, cy, z, v;
      {n, cy, z, v} = f;
      case (c)
         4'h0: cond_met = z;
         4'h1: cond_met = !z;
         4'h2: cond_met = cy;
         4'h3: cond_met = !cy;
         4'h4: cond_met = n;
         4'h5: cond_met = !n;
         4'h6: cond_met = v;
         4'h7: cond_met = !v;
         4'h8: cond_met = cy && !z;
         4'h9: cond_met = !cy || z;
         4'hA: cond_met = (n == v);
         4'hB: cond_met = (n != v);
         4'hC: cond_met = !z && (n == v);
         4'hD: cond_met = z || (n != v);
         4'hE: cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   endfunction

   always_comb begin
      w_res  = '0;
      w_wen  = 1'b0;
      w_setf = 1'b0;
      w_mem  = 1'b0;
      w_mul  = 1'b0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      case (bus.in_class)
         2'd0: begin
            w_setf = bus.in_set_flags;
            w_wen  = 1'b1;
            case (bus.in_op)
               3'd1: begin
                  w_res = w_sum[M:0];
                  w_c   = w_sum[DATA_W];
                  w_v   = (bus.op_a[M] == w_opb[M]) && (w_sum[M] != bus.op_a[M]);
               end
               3'd2: begin
                  w_res = w_dif[M:0];
                  w_c   = !w_dif[DATA_W];
                  w_v   = (bus.op_a[M] != w_opb[M]) && (w_dif[M] != bus.op_a[M]);
               end
               3'd3: w_res = bus.op_a & w_opb;
               3'd4: w_res = bus.op_a | w_opb;
               3'd5: w_res = bus.op_a ^ w_opb;
               3'd6: w_res = ~bus.op_a;
`ifdef EX_MUL_EN
               3'd7: w_mul = 1'b1;
`endif
               default: begin
                  w_wen  = 1'b0;
                  w_setf = 1'b0;
               end
            endcase
         end
         2'd1: begin
            w_wen = 1'b1;
            case (bus.in_op)
               3'd0: w_res = (bus.op_a & ~w_mask_lo) | w_imm_zx;
               3'd1: w_res = MOVT_OK ? ((bus.op_a & ~(w_mask_lo << IMM_W)) | (w_imm_zx << IMM_W))
                                     : ((bus.op_a & ~w_mask_lo) | w_imm_zx);
               3'd2: w_res = '0;
               3'd3: w_res = '1;
               3'd4: w_res = w_sh_big ? '0 : (bus.op_a << bus.imm);
               3'd5: w_res = w_sh_big ? '0 : (bus.op_a >> bus.imm);
               default: w_wen = 1'b0;
            endcase
         end
         2'd2: w_mem = (bus.in_op == 3'd0) || (bus.in_op == 3'd1);
         default: ;
      endcase
      w_nzcv = {w_res[M], w_c, (w_res == '0), w_v};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_wb_en     <= 1'b0;
         r_br_taken  <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_is_load   <= 1'b0;
         r_wb_dest   <= '0;
         r_wb_data   <= '0;
         r_br_offset <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_flags     <= '0;
`ifdef EX_MUL_EN
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_mul_acc   <= '0;
         r_mul_cnt   <= '0;
         r_mul_setf  <= 1'b0;
`endif
      end else begin
         r_out_valid <= 1'b0;
         r_wb_en     <= 1'b0;
         r_br_taken  <= 1'b0;
         case (r_state)
            S_MEM_REQ: if (bus.mem_ack) begin
               r_state     <= S_RESP;
               r_mem_rd    <= 1'b0;
               r_mem_wr    <= 1'b0;
               r_out_valid <= 1'b1;
               r_wb_en     <= r_is_load;
               if (r_is_load) r_wb_data <= bus.mem_rdata;
            end
            S_RESP: r_state <= S_IDLE;
`ifdef EX_MUL_EN
            S_MUL: begin
               r_mul_acc <= w_mul_next;
               r_mul_a   <= r_mul_a << 1;
               r_mul_b   <= r_mul_b >> 1;
               r_mul_cnt <= r_mul_cnt + 1'b1;
               if (r_mul_cnt == CNT_W'(DATA_W - 1)) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b1;
                  r_wb_en     <= 1'b1;
                  r_wb_data   <= w_mul_next;
                  if (r_mul_setf) r_flags <= {w_mul_next[M], 1'b0, (w_mul_next == '0), 1'b0};
               end
            end
`endif
            default: ;
         endcase
         if (w_accept) begin
            r_wb_dest <= bus.in_dest;
            if (w_mem) begin
               r_state   <= S_MEM_REQ;
               r_is_load <= (bus.in_op == 3'd0);
               if (bus.in_op == 3'd0) begin
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= bus.op_a + w_imm_sx;
               end else begin
                  r_mem_wr    <= 1'b1;
                  r_mem_addr  <= bus.op_b + w_imm_sx;
                  r_mem_wdata <= bus.op_a;
               end
            end
`ifdef EX_MUL_EN
            else if (w_mul) begin
               r_state    <= S_MUL;
               r_mul_a    <= bus.op_a;
               r_mul_b    <= w_opb;
               r_mul_acc  <= '0;
               r_mul_cnt  <= '0;
               r_mul_setf <= bus.in_set_flags;
            end
`endif
            else begin
               r_out_valid <= 1'b1;
               r_wb_en     <= w_wen;
               if (bus.in_class == 2'd3) begin
                  r_br_taken  <= cond_met(bus.in_cond, r_flags);
                  r_br_offset <= w_imm_sx;
               end else begin
                  r_wb_data <= w_res;
               end
               if (w_setf) r_flags <= w_nzcv;
            end
         end
      end
   end

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.wb_en     = r_wb_en;
   assign bus.wb_dest   = r_wb_dest;
   assign bus.wb_data   = r_wb_data;
   assign bus.br_taken  = r_br_taken;
   assign bus.br_offset = r_br_offset;
   assign bus.flags     = r_flags;
   assign bus.mem_rd    = r_mem_rd;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
endmodule
